// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Pays out change in nickles, dimes and quarters, largest coin first. Each
// coin is a single-cycle pulse followed by GAP_CYCLES quiet cycles, so the
// vending machine downstream sees well separated pulses.
//
// Optional feature macro: COIN_INVENTORY_EN
//   defined   : stock of each coin is tracked, decremented on every pulse,
//               reloaded by refill (only while idle) and reported on inv_*.
//               When a coin runs out, the shortfall is reported in short_amt.
//   undefined : stock is treated as unlimited, inv_* read 4'hF, and refill
//               has no effect.
//
// Parameters
//   GAP_CYCLES   : quiet cycles after each coin pulse (1-7)
//   INIT_NICKLE  : nickle stock loaded at reset / refill (0-15)
//   INIT_DIME    : dime stock loaded at reset / refill (0-15)
//   INIT_QUARTER : quarter stock loaded at reset / refill (0-15)
//
// Ports
//   clk                  : clock, rising edge
//   rst_n                : synchronous active-low reset
//   req_valid/req_amount : change request (cents), taken when req_ready
//   req_ready            : high only when idle
//   refill               : one-cycle pulse, reloads stock while idle
//   nickle/dime/quarter  : coin pulses, at most one high per cycle
//   busy                 : high whenever not idle
//   done                 : one-cycle completion pulse
//   err                  : request was malformed (valid with done, held)
//   short_amt            : cents not paid out (valid with done, held)
//   inv_nickle/dime/quarter : current stock
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int GAP_CYCLES   = 2,
    parameter int INIT_NICKLE  = 8,
    parameter int INIT_DIME    = 8,
    parameter int INIT_QUARTER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [6:0] req_amount,
    output logic       req_ready,
    input  logic       refill,
    output logic       nickle,
    output logic       dime,
    output logic       quarter,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] short_amt,
    output logic [3:0] inv_nickle,
    output logic [3:0] inv_dime,
    output logic [3:0] inv_quarter
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // Encoding doubles as (stock index + 1) for the inventory generate loop.
    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_N    = 2'd1,
        COIN_D    = 2'd2,
        COIN_Q    = 2'd3
    } coin_t;

    state_t     state_reg, state_next;
    coin_t      coin_reg, coin_next;
    logic [6:0] remaining_reg;
    logic [2:0] gap_cnt_reg;
    logic       malformed_reg;
    logic       err_reg;
    logic [6:0] short_reg;

    // Live stock per coin, index 0 = nickle, 1 = dime, 2 = quarter.
    logic [3:0] stock [3];
    logic       have_coin [3];

    logic accept;
    logic req_malformed;

    assign accept        = req_valid && (state_reg == S_IDLE);
    assign req_malformed = ((req_amount % 7'd5) != 7'd0) || (req_amount > 7'd100);

    function automatic logic [6:0] coin_value(input coin_t c);
        case (c)
            COIN_N:  coin_value = 7'd5;
            COIN_D:  coin_value = 7'd10;
            COIN_Q:  coin_value = 7'd25;
            default: coin_value = 7'd0;
        endcase
    endfunction

`ifdef COIN_INVENTORY_EN
    logic reload;
    assign reload = refill && (state_reg == S_IDLE);

    // Refill is only honoured while idle, so it can never collide with a
    // decrement (decrements happen only in PULSE). A refill in the same
    // cycle as an acceptance lands before the request reaches SELECT.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stock
            localparam logic [3:0] INIT_V = (gi == 0) ? 4'(INIT_NICKLE) :
                                            (gi == 1) ? 4'(INIT_DIME)   :
                                                        4'(INIT_QUARTER);
            logic [3:0] stock_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stock_reg <= INIT_V;
                end else if (reload) begin
                    stock_reg <= INIT_V;
                end else if ((state_reg == S_PULSE) && (coin_reg == coin_t'(gi + 1))
                             && (stock_reg != 4'd0)) begin
                    stock_reg <= stock_reg - 4'd1;
                end
            end

            assign stock[gi]     = stock_reg;
            assign have_coin[gi] = (stock_reg != 4'd0);
        end
    endgenerate
`else
    logic unused_refill;
    assign unused_refill = refill;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stock
            assign stock[gi]     = 4'hF;
            assign have_coin[gi] = 1'b1;
        end
    endgenerate
`endif

    assign inv_nickle  = stock[0];
    assign inv_dime    = stock[1];
    assign inv_quarter = stock[2];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            coin_reg  <= COIN_NONE;
        end else begin
            state_reg <= state_next;
            coin_reg  <= coin_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        coin_next  = coin_reg;
        case (state_reg)
            S_IDLE: begin
                coin_next = COIN_NONE;
                if (accept) begin
                    state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                coin_next = COIN_NONE;
                if (malformed_reg || (remaining_reg == 7'd0)) begin
                    state_next = S_DONE;
                end else if ((remaining_reg >= 7'd25) && have_coin[2]) begin
                    coin_next  = COIN_Q;
                    state_next = S_PULSE;
                end else if ((remaining_reg >= 7'd10) && have_coin[1]) begin
                    coin_next  = COIN_D;
                    state_next = S_PULSE;
                end else if ((remaining_reg >= 7'd5) && have_coin[0]) begin
                    coin_next  = COIN_N;
                    state_next = S_PULSE;
                end else begin
                    // Something is still owed but nothing fits: report short.
                    state_next = S_DONE;
                end
            end
            S_PULSE: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_reg == 3'(GAP_CYCLES - 1)) begin
                    state_next = S_SELECT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                coin_next  = COIN_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining_reg <= 7'd0;
            gap_cnt_reg   <= 3'd0;
            malformed_reg <= 1'b0;
            err_reg       <= 1'b0;
            short_reg     <= 7'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        remaining_reg <= req_amount;
                        malformed_reg <= req_malformed;
                        err_reg       <= 1'b0;
                        short_reg     <= 7'd0;
                    end
                end
                S_SELECT: begin
                    // Result is captured on the way into DONE so it is valid
                    // during the done pulse and held until the next request.
                    if (state_next == S_DONE) begin
                        short_reg <= remaining_reg;
                        err_reg   <= malformed_reg;
                    end
                end
                S_PULSE: begin
                    remaining_reg <= remaining_reg - coin_value(coin_reg);
                    gap_cnt_reg   <= 3'd0;
                end
                S_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    assign req_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign nickle    = (state_reg == S_PULSE) && (coin_reg == COIN_N);
    assign dime      = (state_reg == S_PULSE) && (coin_reg == COIN_D);
    assign quarter   = (state_reg == S_PULSE) && (coin_reg == COIN_Q);
    assign err       = err_reg;
    assign short_amt = short_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//
// Directed bench for change_dispenser. Two instances share clock, reset and
// refill: "dut" with default stock, "lo" with quarters 0 / dimes 1 /
// nickles 1 for the exhausted-stock cases. Cycle k is the clock period that
// ends k rising edges after the acceptance edge; outputs are sampled on the
// falling edge inside that period. Coins are observed as {quarter,dime,nickle}.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refill;

    logic       req_valid;
    logic [6:0] req_amount;
    logic       req_ready, nickle, dime, quarter, busy, done, err;
    logic [6:0] short_amt;
    logic [3:0] inv_nickle, inv_dime, inv_quarter;

    logic       lo_valid;
    logic [6:0] lo_amount;
    logic       lo_ready, lo_nickle, lo_dime, lo_quarter, lo_busy, lo_done, lo_err;
    logic [6:0] lo_short;
    logic [3:0] lo_inv_n, lo_inv_d, lo_inv_q;

    int total = 0;
    int bad   = 0;

    localparam int MAXC = 24;
    logic [2:0] obs_coin  [1:MAXC];
    logic       obs_busy  [1:MAXC];
    logic       obs_ready [1:MAXC];
    logic [6:0] obs_short [1:MAXC];
    logic       obs_err   [1:MAXC];
    int         done_cyc;
    int         done_cnt;

    always #5 clk = ~clk;

    change_dispenser #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .refill(refill),
        .nickle(nickle), .dime(dime), .quarter(quarter),
        .busy(busy), .done(done), .err(err), .short_amt(short_amt),
        .inv_nickle(inv_nickle), .inv_dime(inv_dime), .inv_quarter(inv_quarter)
    );

    change_dispenser #(.GAP_CYCLES(2), .INIT_NICKLE(1), .INIT_DIME(1), .INIT_QUARTER(0)) lo (
        .clk(clk), .rst_n(rst_n),
        .req_valid(lo_valid), .req_amount(lo_amount), .req_ready(lo_ready),
        .refill(refill),
        .nickle(lo_nickle), .dime(lo_dime), .quarter(lo_quarter),
        .busy(lo_busy), .done(lo_done), .err(lo_err), .short_amt(lo_short),
        .inv_nickle(lo_inv_n), .inv_dime(lo_inv_d), .inv_quarter(lo_inv_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_inv(input logic [3:0] v);
`ifdef COIN_INVENTORY_EN
        return v;
`else
        return 4'hF;
`endif
    endfunction

    // Issue one request and record ncyc cycles of outputs. rst_cyc / rfl_cyc
    // select a cycle in which rst_n is held low / refill is pulsed (0 for
    // refill means together with the request; -1 means never).
    task automatic run_req(input bit use_lo, input logic [6:0] amt,
                           input int rst_cyc, input int rfl_cyc, input int ncyc);
        @(negedge clk);
        if (use_lo) begin
            lo_valid = 1'b1; lo_amount = amt;
        end else begin
            req_valid = 1'b1; req_amount = amt;
        end
        if (rfl_cyc == 0) refill = 1'b1;
        chk("ready_before_accept", use_lo ? lo_ready : req_ready, 1);
        @(posedge clk);
        done_cyc = 0;
        done_cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            // Garbage on the request lines while busy must be ignored.
            req_valid = 1'b0; lo_valid = 1'b0;
            req_amount = 7'd55; lo_amount = 7'd55;
            refill = 1'b0;
            rst_n  = (k == rst_cyc) ? 1'b0 : 1'b1;
            if (k == rfl_cyc) refill = 1'b1;
            if (use_lo) begin
                obs_coin[k]  = {lo_quarter, lo_dime, lo_nickle};
                obs_busy[k]  = lo_busy;
                obs_ready[k] = lo_ready;
                obs_short[k] = lo_short;
                obs_err[k]   = lo_err;
                if (lo_done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
            end else begin
                obs_coin[k]  = {quarter, dime, nickle};
                obs_busy[k]  = busy;
                obs_ready[k] = req_ready;
                obs_short[k] = short_amt;
                obs_err[k]   = err;
                if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
            end
        end
        @(negedge clk);
        rst_n = 1'b1; refill = 1'b0;
        $display("txn %s amt=%0d done_cyc=%0d done_cnt=%0d short=%0d err=%0d",
                 use_lo ? "lo" : "dut", amt, done_cyc, done_cnt,
                 (done_cyc != 0) ? obs_short[done_cyc] : 7'd0,
                 (done_cyc != 0) ? obs_err[done_cyc] : 1'b0);
    endtask

    // Up to three coin events (cycle, {q,d,n}); every other cycle must be quiet.
    task automatic check_coins(input string tag, input int n,
                               input int ca, input logic [2:0] va,
                               input int cb, input logic [2:0] vb,
                               input int cc, input logic [2:0] vc);
        logic [2:0] e;
        for (int k = 1; k <= n; k++) begin
            e = (k == ca) ? va : (k == cb) ? vb : (k == cc) ? vc : 3'b000;
            chk($sformatf("%s_coin_c%0d", tag, k), obs_coin[k], e);
        end
    endtask

    task automatic check_done(input string tag, input int cyc,
                              input logic [6:0] s, input logic e);
        chk({tag, "_done_cyc"}, done_cyc, cyc);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (done_cyc != 0) begin
            chk({tag, "_short"}, obs_short[done_cyc], s);
            chk({tag, "_err"}, obs_err[done_cyc], e);
        end
    endtask

    task automatic check_inv(input string tag, input logic [3:0] n,
                             input logic [3:0] d, input logic [3:0] q);
        chk({tag, "_inv_n"}, inv_nickle, exp_inv(n));
        chk({tag, "_inv_d"}, inv_dime, exp_inv(d));
        chk({tag, "_inv_q"}, inv_quarter, exp_inv(q));
    endtask

    localparam logic [2:0] CQ = 3'b100;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CN = 3'b001;

    initial begin
        rst_n = 1'b0; refill = 1'b0;
        req_valid = 1'b0; req_amount = 7'd0;
        lo_valid = 1'b0; lo_amount = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coins", {quarter, dime, nickle}, 0);
        chk("rst_short", short_amt, 0);
        chk("rst_err", err, 0);
        check_inv("rst", 4'd8, 4'd8, 4'd8);
        rst_n = 1'b1;
        @(negedge clk);

        // Amount 40: quarter, dime, nickle at 4-cycle spacing.
        run_req(1'b0, 7'd40, -1, -1, 16);
        check_coins("a40", 16, 2, CQ, 6, CD, 10, CN);
        check_done("a40", 14, 7'd0, 1'b0);
        chk("a40_busy_c3", obs_busy[3], 1);
        chk("a40_ready_c3", obs_ready[3], 0);
        check_inv("a40", 4'd7, 4'd7, 4'd7);

        // Amount 0: straight to done.
        run_req(1'b0, 7'd0, -1, -1, 5);
        check_coins("a0", 5, 0, 0, 0, 0, 0, 0);
        check_done("a0", 2, 7'd0, 1'b0);

        // Malformed amounts: no coins, err, short = amount, held afterwards.
        run_req(1'b0, 7'd37, -1, -1, 5);
        check_coins("a37", 5, 0, 0, 0, 0, 0, 0);
        check_done("a37", 2, 7'd37, 1'b1);
        chk("a37_short_hold", obs_short[4], 37);
        chk("a37_err_hold", obs_err[4], 1);

        run_req(1'b0, 7'd105, -1, -1, 5);
        check_coins("a105", 5, 0, 0, 0, 0, 0, 0);
        check_done("a105", 2, 7'd105, 1'b1);
        check_inv("malformed", 4'd7, 4'd7, 4'd7);

        // Amount 50 with reset in cycle 7: second quarter already out,
        // nothing afterwards, no done, stock reloaded.
        run_req(1'b0, 7'd50, 7, -1, 14);
        check_coins("a50rst", 14, 2, CQ, 6, CQ, 0, 0);
        chk("a50rst_done_cnt", done_cnt, 0);
        chk("a50rst_ready_c9", obs_ready[9], 1);
        chk("a50rst_busy_c9", obs_busy[9], 0);
        check_inv("a50rst", 4'd8, 4'd8, 4'd8);

        // Refill while busy is ignored; refill while idle restores stock.
        run_req(1'b0, 7'd10, -1, 4, 8);
        check_coins("a10rfl", 8, 2, CD, 0, 0, 0, 0);
        check_done("a10rfl", 6, 7'd0, 1'b0);
        check_inv("busy_refill", 4'd8, 4'd7, 4'd8);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        @(negedge clk);
        check_inv("idle_refill", 4'd8, 4'd8, 4'd8);

        // Limited-stock instance, amount 25.
`ifdef COIN_INVENTORY_EN
        run_req(1'b1, 7'd25, -1, -1, 12);
        check_coins("lo25", 12, 2, CD, 6, CN, 0, 0);
        check_done("lo25", 10, 7'd10, 1'b0);
        chk("lo25_inv", {lo_inv_q, lo_inv_d, lo_inv_n}, 12'h000);
        // Stock exhausted: nothing paid.
        run_req(1'b1, 7'd25, -1, -1, 5);
        check_coins("lo25x", 5, 0, 0, 0, 0, 0, 0);
        check_done("lo25x", 2, 7'd25, 1'b0);
        // Refill together with acceptance: request sees reloaded stock.
        run_req(1'b1, 7'd25, -1, 0, 12);
        check_coins("lo25r", 12, 2, CD, 6, CN, 0, 0);
        check_done("lo25r", 10, 7'd10, 1'b0);
`else
        run_req(1'b1, 7'd25, -1, -1, 8);
        check_coins("lo25", 8, 2, CQ, 0, 0, 0, 0);
        check_done("lo25", 6, 7'd0, 1'b0);
        chk("lo25_inv", {lo_inv_q, lo_inv_d, lo_inv_n}, 12'hFFF);
        run_req(1'b1, 7'd25, -1, 0, 8);
        check_coins("lo25r", 8, 2, CQ, 0, 0, 0, 0);
        check_done("lo25r", 6, 7'd0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles after each coin pulse (range 1-7).
REQ-002 SHALL have parameters INIT_NICKLE, INIT_DIME, INIT_QUARTER, default 8 each: coin stock loaded at reset (range 0-15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  change request present.
REQ-006 SHALL have port req_amount  input  7  change owed in cents.
REQ-007 SHALL have port req_ready  output  1  high only in IDLE.
REQ-008 SHALL have port refill  input  1  one-cycle pulse reloading stock to INIT values.
REQ-009 SHALL have ports nickle, dime, quarter  output  1 each  coin pulses, at most one high per cycle, same encoding the vending machine consumes.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; request was malformed.
REQ-013 SHALL have port short_amt  output  7  valid with done; cents not dispensed.
REQ-014 SHALL have ports inv_nickle, inv_dime, inv_quarter  output  4 each  current stock.

Function
REQ-015 SHALL implement states IDLE, SELECT, PULSE, GAP, DONE.
REQ-016 SHALL accept a request when req_valid and req_ready are high at a rising edge, latch req_amount into a 7-bit remaining register, and enter SELECT.
REQ-017 SHALL mark a request malformed when req_amount is not a multiple of 5 or exceeds 100; SELECT then goes to DONE with err=1, short_amt=req_amount, and no coins issued.
REQ-018 SHALL choose the coin in SELECT greedily: quarter if remaining>=25 and stock>0, else dime if remaining>=10 and stock>0, else nickle if remaining>=5 and stock>0; then go to PULSE.
REQ-019 SHALL go from SELECT to DONE when remaining==0, or when remaining>0 and no coin can be chosen (stock exhausted).
REQ-020 SHALL raise exactly the chosen coin output for the single PULSE cycle, subtract 5/10/25 from remaining, and decrement that stock by 1 at the end of the cycle.
REQ-021 SHALL hold all coin outputs low for exactly GAP_CYCLES cycles in GAP, then return to SELECT.
REQ-022 SHALL assert done for one cycle in DONE, drive short_amt=remaining and err as determined, then return to IDLE; short_amt and err SHALL hold until the next acceptance.
REQ-023 SHALL issue the first coin pulse 2 cycles after the acceptance edge; consecutive pulses SHALL be GAP_CYCLES+2 cycles apart.
REQ-024 SHALL apply refill only in IDLE; a refill while busy SHALL be ignored; refill and acceptance in the same IDLE cycle SHALL reload stock first, so the new request uses the reloaded stock.
REQ-025 SHALL ignore req_valid and req_amount changes while busy.

Reset
REQ-026 SHALL, at any rising edge with rst_n low, including mid-dispense, enter IDLE, clear remaining, short_amt and err, drive nickle, dime, quarter, busy and done low, and reload stock to the INIT values; req_ready SHALL be high on the following cycle.

Configuration
REQ-027 SHALL, with COIN_INVENTORY_EN defined, track stock per REQ-018/019/020/024 and drive inv_* with the live counts.
REQ-028 SHALL, without COIN_INVENTORY_EN, treat stock as unlimited: inv_* tied to 4'hF, no decrements, refill ignored, short_amt always 0 for well-formed requests.

Verification (GAP_CYCLES=2, acceptance edge = cycle 0)
REQ-029 SHALL check amount 40: quarter in cycle 2, dime in cycle 6, nickle in cycle 10, done in cycle 14, short_amt=0, err=0, stock 7/7/7.
REQ-030 SHALL check amount 0: no coin pulses, done in cycle 2, short_amt=0, err=0.
REQ-031 SHALL check amount 37 and amount 105: no coins, done in cycle 2, err=1, short_amt=37 and 105 respectively.
REQ-032 SHALL check INIT_QUARTER=0, INIT_DIME=1, INIT_NICKLE=1, amount 25 with COIN_INVENTORY_EN: dime, then nickle, then done with short_amt=10; without the macro: a single quarter and short_amt=0.
REQ-033 SHALL check that rst_n low in cycle 7 during amount 50 leaves all coin outputs low from cycle 8 on, no done pulse, and req_ready high from cycle 9.
REQ-034 SHALL check that refill pulsed in cycle 4 of a dispense leaves stock unchanged, and that refill in IDLE restores 8/8/8.
